// File: rtl/bht_update_ctrl.sv
// Update scheduler and clear walker for the 64-entry 2-bit BHT write port.
// Optional macro BHT_UPDATE_BYPASS_EN: drive an update straight to the table when the FIFO is empty.
module bht_update_ctrl #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ENTRIES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [15:0] ex_pc,
    input  logic        ex_taken,
    input  logic        ret_valid,
    output logic        ret_ready,
    input  logic [15:0] ret_pc,
    input  logic        ret_taken,
    output logic        bht_write,
    output logic [15:0] bht_write_pc,
    output logic        bht_taken,
    output logic        busy
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned FW = CW + 1;
    localparam int unsigned IW = $clog2(ENTRIES);
    localparam int unsigned PW = 16;
    localparam logic [IW-1:0] LAST_IDX  = IW'(ENTRIES - 1);
    localparam logic [1:0]    LAST_PASS = 2'd2;

    typedef enum logic {S_CLEAR, S_RUN} state_t;
    typedef struct packed {
        logic [PW-1:0] pc;
        logic          taken;
    } entry_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [1:0]    pass;
    entry_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          rr_ret;

    logic          run;
    logic          empty;
    logic          pop;
    logic          contended;
    logic          ex_acc;
    logic          ret_acc;
    logic          bypass;
    logic [FW-1:0] free;
    logic [1:0]    n_enq;
    entry_t        ex_ent;
    entry_t        ret_ent;
    entry_t        enq_a;
    entry_t        enq_b;
    entry_t        byp_ent;

    // Arbitration, enqueue selection and write-port drive
    always_comb begin
        run       = (state == S_RUN);
        empty     = (count == '0);
        pop       = run && !empty && !flush;
        free      = FW'(DEPTH) - FW'(count) + FW'(pop);
        ex_ready  = 1'b0;
        ret_ready = 1'b0;
        if (run) begin
            if (free >= FW'(2)) begin
                ex_ready  = 1'b1;
                ret_ready = 1'b1;
            end else if (free == FW'(1)) begin
                // One slot: each side yields only if the other is valid and holds the pointer
                ex_ready  = !ret_valid || !rr_ret;
                ret_ready = !ex_valid || rr_ret;
            end
        end
        ex_acc    = ex_valid && ex_ready;
        ret_acc   = ret_valid && ret_ready;
        contended = run && (free == FW'(1)) && ex_valid && ret_valid;
        ex_ent    = '{pc: ex_pc, taken: ex_taken};
        ret_ent   = '{pc: ret_pc, taken: ret_taken};
`ifdef BHT_UPDATE_BYPASS_EN
        bypass    = run && empty && !flush && (ex_acc || ret_acc);
`else
        bypass    = 1'b0;
`endif
        byp_ent   = ex_acc ? ex_ent : ret_ent;
        enq_a     = ex_acc ? ex_ent : ret_ent;
        enq_b     = ret_ent;
        n_enq     = 2'(ex_acc) + 2'(ret_acc);
        if (bypass) begin
            enq_a = ret_ent;
            n_enq = 2'(ex_acc && ret_acc);
        end

        bht_write    = 1'b0;
        bht_write_pc = '0;
        bht_taken    = 1'b0;
        if (reset_n && !flush) begin
            if (!run) begin
                bht_write    = 1'b1;
                bht_write_pc = {{(PW - IW - 1){1'b0}}, idx, 1'b0};
            end else if (!empty) begin
                bht_write    = 1'b1;
                bht_write_pc = mem[rd_ptr].pc;
                bht_taken    = mem[rd_ptr].taken;
            end else if (bypass) begin
                bht_write    = 1'b1;
                bht_write_pc = byp_ent.pc;
                bht_taken    = byp_ent.taken;
            end
        end
        busy = !run;
    end

    // Clear walk, FIFO pointers and round-robin pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_CLEAR;
            idx    <= '0;
            pass   <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            rr_ret <= 1'b0;
        end else if (flush) begin
            state  <= S_CLEAR;
            idx    <= '0;
            pass   <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (state == S_CLEAR) begin
            if (pass == LAST_PASS) begin
                pass <= '0;
                idx  <= idx + IW'(1);
                if (idx == LAST_IDX) state <= S_RUN;
            end else begin
                pass <= pass + 2'd1;
            end
        end else begin
            if (contended) rr_ret <= !rr_ret;
            rd_ptr <= rd_ptr + AW'(pop);
            wr_ptr <= wr_ptr + AW'(n_enq);
            count  <= count - CW'(pop) + CW'(n_enq);
        end
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (run && !flush) begin
            if (n_enq != 2'd0) mem[wr_ptr] <= enq_a;
            if (n_enq == 2'd2) mem[wr_ptr + AW'(1)] <= enq_b;
        end
    end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Randomized self-checking bench for bht_update_ctrl against a queue-based model.
module tb_bht_update_ctrl;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned ENTRIES   = 64;
    localparam int          CLEAR_LEN = 3 * ENTRIES;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [15:0] ex_pc;
    logic        ex_taken;
    logic        ret_valid;
    logic        ret_ready;
    logic [15:0] ret_pc;
    logic        ret_taken;
    logic        bht_write;
    logic [15:0] bht_write_pc;
    logic        bht_taken;
    logic        busy;

    bht_update_ctrl #(.DEPTH(DEPTH), .ENTRIES(ENTRIES)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_pc(ret_pc), .ret_taken(ret_taken),
        .bht_write(bht_write), .bht_write_pc(bht_write_pc), .bht_taken(bht_taken),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic        taken;
    } upd_t;

    upd_t q[$];
    bit   m_clear;
    int   clr_n;
    bit   rr;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_clear = 1'b1;
        clr_n   = 0;
        rr      = 1'b0;
    endtask

    // One clock: drive inputs, check outputs at negedge, advance the model at posedge
    task automatic step(input bit ev, input logic [15:0] ep, input bit et,
                        input bit rv, input logic [15:0] rp, input bit rt, input bit fl);
        bit          e_exr, e_retr, e_wr, e_tk, pop, byp, exa, reta;
        logic [15:0] e_pc;
        int          free;
        upd_t        u;
        ex_valid  = ev;  ex_pc  = ep; ex_taken  = et;
        ret_valid = rv;  ret_pc = rp; ret_taken = rt;
        flush     = fl;
        @(negedge clk);
        e_exr = 0; e_retr = 0; e_wr = 0; e_tk = 0; e_pc = '0; pop = 0; byp = 0; free = 0;
        if (m_clear) begin
            if (!fl) begin
                e_wr = 1;
                e_pc = 16'((clr_n / 3) * 2);
            end
        end else begin
            pop  = (q.size() != 0) && !fl;
            free = DEPTH - q.size() + (pop ? 1 : 0);
            if (free >= 2) begin
                e_exr = 1; e_retr = 1;
            end else if (free == 1) begin
                e_exr  = rv ? !rr : 1'b1;
                e_retr = ev ? rr : 1'b1;
            end
            if (pop) begin
                e_wr = 1; e_pc = q[0].pc; e_tk = q[0].taken;
            end
`ifdef BHT_UPDATE_BYPASS_EN
            if (q.size() == 0 && !fl && (ev || rv)) begin
                byp = 1; e_wr = 1;
                e_pc = ev ? ep : rp;
                e_tk = ev ? et : rt;
            end
`endif
        end
        check("bht_write", 32'(bht_write), 32'(e_wr));
        if (e_wr) begin
            check("bht_write_pc", 32'(bht_write_pc), 32'(e_pc));
            check("bht_taken", 32'(bht_taken), 32'(e_tk));
        end
        check("ex_ready", 32'(ex_ready), 32'(e_exr));
        check("ret_ready", 32'(ret_ready), 32'(e_retr));
        check("busy", 32'(busy), 32'(m_clear));
        @(posedge clk);
        exa  = ev && e_exr;
        reta = rv && e_retr;
        if (fl) begin
            q.delete();
            m_clear = 1'b1;
            clr_n   = 0;
        end else if (m_clear) begin
            clr_n++;
            if (clr_n == CLEAR_LEN) m_clear = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (ev && rv && free == 1) rr = !rr;
            if (exa && !byp) begin
                u = '{pc: ep, taken: et};
                q.push_back(u);
            end
            if (reta && !(byp && !exa)) begin
                u = '{pc: rp, taken: rt};
                q.push_back(u);
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 16'h0, 0, 0, 16'h0, 0, 0);
    endtask

    task automatic both(input int n);
        repeat (n) step(1, 16'($urandom), $urandom_range(0, 1) == 1,
                        1, 16'($urandom), $urandom_range(0, 1) == 1, 0);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_write"}, 32'(bht_write), 32'd0);
        check({tag, "_pc"}, 32'(bht_write_pc), 32'd0);
        check({tag, "_taken"}, 32'(bht_taken), 32'd0);
        check({tag, "_ex_ready"}, 32'(ex_ready), 32'd0);
        check({tag, "_ret_ready"}, 32'(ret_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0;
        ex_valid = 1'b0; ex_pc = '0; ex_taken = 1'b0;
        ret_valid = 1'b0; ret_pc = '0; ret_taken = 1'b0;
        model_reset();
        #3;
        reset_checks("reset");
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Post-reset clear walk, then a single ex update
        idle(CLEAR_LEN + 4);
        step(1, 16'h3046, 1, 0, 16'h0, 0, 0);
        idle(3);

        // Sustained contention with the FIFO near full
        both(20);
        idle(6);

        // Fill to DEPTH and flush with requests pending
        both(3);
        step(1, 16'h1234, 1, 1, 16'h5678, 1, 1);
        idle(20 * 3);
        step(0, 16'h0, 0, 0, 16'h0, 0, 1);
        idle(CLEAR_LEN + 3);

        // Asynchronous reset mid-drain with three entries queued
        both(2);
        ex_valid  = 1'b0;
        ret_valid = 1'b0;
        reset_n   = 1'b0;
        #1;
        reset_checks("async_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        idle(CLEAR_LEN + 3);

        // Random traffic with occasional flushes
        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 299) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
